// File: rtl/tug_scorer.sv
// Rope-position tracker and win detector for the tug-of-war game.
// Turns debounced pull buttons into one-LED rope moves on the game tick,
// detects a win at either end, and keeps a saturating per-player tally.
//
// state | meaning
// ------+------------------------------------------------------------
// READY | rope centred, waiting for both buttons released
// PLAY  | round in progress, presses accumulate and apply on slowen
// WIN   | rope frozen at a win pattern until clr starts a new round
module tug_scorer (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic       leftp,
    input  logic       rightp,
    input  logic       clr,
    output logic [6:0] score,
    output logic       wingame,
    output logic       winner,
    output logic [3:0] left_tally,
    output logic [3:0] right_tally
);

    typedef enum logic [1:0] {
        ST_READY,
        ST_PLAY,
        ST_WIN
    } state_t;

    state_t            state_q, state_d;
    logic signed [3:0] pos_q, pos_d;
    logic              lprev_q, lprev_d;
    logic              rprev_q, rprev_d;
    logic              lpend_q, lpend_d;
    logic              rpend_q, rpend_d;
    logic [6:0]        score_q, score_d;
    logic              wingame_q, wingame_d;
    logic              winner_q, winner_d;
    logic [3:0]        ltally_q, ltally_d;
    logic [3:0]        rtally_q, rtally_d;

    logic              lpress, rpress;
    logic              l_eff, r_eff;
    logic signed [3:0] pos_move;

    // Rope position to LED pattern; the end positions light three LEDs.
    function automatic logic [6:0] encode(input logic [3:0] p);
        logic [6:0] pat;
        case (p)
            4'b0100: pat = 7'b0000111;
            4'b0011: pat = 7'b0000001;
            4'b0010: pat = 7'b0000010;
            4'b0001: pat = 7'b0000100;
            4'b0000: pat = 7'b0001000;
            4'b1111: pat = 7'b0010000;
            4'b1110: pat = 7'b0100000;
            4'b1101: pat = 7'b1000000;
            4'b1100: pat = 7'b1110000;
            default: pat = 7'b0001000;
        endcase
        return pat;
    endfunction

    // Next-state logic: edge detect, pending flags, rope moves and win handling.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        lpend_d   = lpend_q;
        rpend_d   = rpend_q;
        wingame_d = wingame_q;
        winner_d  = winner_q;
        ltally_d  = ltally_q;
        rtally_d  = rtally_q;
        lprev_d   = leftp;
        rprev_d   = rightp;

        lpress = leftp & ~lprev_q;
        rpress = rightp & ~rprev_q;
        // A press landing on the tick cycle itself still counts for that tick.
        l_eff  = lpend_q | lpress;
        r_eff  = rpend_q | rpress;

        pos_move = pos_q;
        if (r_eff && !l_eff) begin
            pos_move = pos_q + 4'sd1;
        end else if (l_eff && !r_eff) begin
            pos_move = pos_q - 4'sd1;
        end

        case (state_q)
            ST_READY: begin
                pos_d   = 4'sd0;
                lpend_d = 1'b0;
                rpend_d = 1'b0;
                if (!leftp && !rightp) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (slowen) begin
                    lpend_d = 1'b0;
                    rpend_d = 1'b0;
                    pos_d   = pos_move;
                    if (pos_move == 4'sd4) begin
                        state_d   = ST_WIN;
                        winner_d  = 1'b1;
                        wingame_d = 1'b1;
                        rtally_d  = (rtally_q == 4'hF) ? rtally_q : rtally_q + 4'd1;
                    end else if (pos_move == -4'sd4) begin
                        state_d   = ST_WIN;
                        winner_d  = 1'b0;
                        wingame_d = 1'b1;
                        ltally_d  = (ltally_q == 4'hF) ? ltally_q : ltally_q + 4'd1;
                    end
                end else begin
                    lpend_d = l_eff;
                    rpend_d = r_eff;
                end
            end
            ST_WIN: begin
                lpend_d = 1'b0;
                rpend_d = 1'b0;
                // clr takes priority over a coincident tick.
                if (clr) begin
                    pos_d     = 4'sd0;
                    wingame_d = 1'b0;
                    state_d   = ST_READY;
                end else if (slowen) begin
                    wingame_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_READY;
                pos_d   = 4'sd0;
            end
        endcase

        score_d = encode(pos_d);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_READY;
            pos_q     <= 4'sd0;
            lprev_q   <= 1'b1;
            rprev_q   <= 1'b1;
            lpend_q   <= 1'b0;
            rpend_q   <= 1'b0;
            score_q   <= 7'b0001000;
            wingame_q <= 1'b0;
            winner_q  <= 1'b0;
            ltally_q  <= 4'd0;
            rtally_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            lprev_q   <= lprev_d;
            rprev_q   <= rprev_d;
            lpend_q   <= lpend_d;
            rpend_q   <= rpend_d;
            score_q   <= score_d;
            wingame_q <= wingame_d;
            winner_q  <= winner_d;
            ltally_q  <= ltally_d;
            rtally_q  <= rtally_d;
        end
    end

    assign score       = score_q;
    assign wingame     = wingame_q;
    assign winner      = winner_q;
    assign left_tally  = ltally_q;
    assign right_tally = rtally_q;

endmodule

// File: doc/tug_scorer.md
# tug_scorer

Rope-position tracker and win detector for the tug-of-war game. It consumes the two players' debounced pull buttons, moves the rope marker one LED per accepted pull on the slow game tick, and drives the 7-bit `score` LED pattern and the `wingame` strobe. The victory animator consumes both signals and recognises `7'b0000111` as a right win and `7'b1110000` as a left win. It also keeps a per-player round tally.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `slowen` in 1: one-`clk`-wide game-tick enable; moves are applied only on cycles with `slowen=1`.
- `leftp` in 1: left player button, debounced level, 1 = pressed.
- `rightp` in 1: right player button, debounced level, 1 = pressed.
- `clr` in 1: start a new round; honoured only in WIN.
- `score` out 7: rope LED pattern; bit 6 is the leftmost LED.
- `wingame` out 1: win strobe, high for exactly one `slowen` period.
- `winner` out 1: 1 = right won the last round, 0 = left; valid while in WIN.
- `left_tally` out 4: left rounds won, saturating.
- `right_tally` out 4: right rounds won, saturating.

## Operation
- Position `pos` is a signed value in −4..+4. Reset value is 0.
- Score encoding: `pos` in −3..+3 gives one-hot `score = 7'b0001000 >> pos` (negative shifts left). `pos=+4` gives `7'b0000111`. `pos=−4` gives `7'b1110000`.
- Edge detect: registered copies `lprev`/`rprev` reset to 1, so a button held through reset is not a press. A press is `leftp & ~lprev` (same for right), evaluated every `clk`.
- Pending flags `lpend`/`rpend`:
  - Each is set by a press on any `clk`.
  - Both are cleared on every `slowen` cycle, after being consumed.
  - A press on the same cycle as `slowen` counts toward that tick.
  - Multiple presses within one tick count once.
- States:
  - READY (reset state): `pos=0`. Pending flags are held clear. Go to PLAY on the first cycle with `leftp=0` and `rightp=0`.
  - PLAY: on `slowen`:
    - `lpend` only: `pos−1`.
    - `rpend` only: `pos+1`.
    - Both, or neither: no move (simultaneous pulls cancel).
    - If the new `pos` is ±4: go to WIN. Set `winner` (+4 gives 1). Assert `wingame`. Increment the winner's tally, saturating at 15.
  - WIN: `score` frozen at the win pattern. Presses are ignored and pending flags held clear. `clr=1` gives `pos=0`, `wingame=0`, and a transition to READY.
- `wingame` timing: rises on the winning `slowen` edge and falls on the next `slowen` edge, or on the `clr` edge if that comes first.
- Reset values of outputs: `score=7'b0001000`, `wingame=0`, `winner=0`, `left_tally=0`, `right_tally=0`.
- Reset mid-round or in WIN clears everything, including tallies.
- `clr` in READY or PLAY has no effect.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Press to `score` change: `score` changes on the first `slowen` edge at or after the press edge. It is visible the cycle after that edge.
- Win: `score`, `winner`, tally and `wingame` all update on the same `clk` edge.
- `wingame` pulse width is exactly one tick interval, so the tick-clocked victory animator always samples it high once.
- Saturation: a tally at 15 stays 15 and never wraps to 0.
- `clr` and `slowen` on the same cycle in WIN: `clr` wins. The block goes to READY and `pos` is 0.

## Test plan
- Reset with `leftp=1` held, then release, then press `rightp` once and pulse `slowen` → `score` goes 0001000 → 0000100. There is no move from the held left button.
- Right presses on 4 successive ticks from center → `score` sequence 0000100, 0000010, 0000001, 0000111. `wingame=1` for one tick period, `winner=1`, `right_tally=1`.
- Left and right pressed in the same tick from `pos=+2` → `score` stays 0000010. Then left only → 0000100.
- Three left presses within one tick → single move: `score` goes 0001000 → 0010000.
- In WIN (left, `score=1110000`): presses are ignored. `clr` and `slowen` together → READY with `score=0001000` and `wingame=0`. Then 4 left presses → `left_tally=2`.
- Drive 16 right wins → `right_tally` holds 15. Reset mid-round at `pos=−3` → `score=0001000`, both tallies 0, `wingame=0`.
